// File: rtl/cluster_core_data_demux_pkg.sv
// Shared types for the core data port demux: request/response structs, destination enum, error read data.
// Also provides the address-window helper used by the decoder.
package cluster_core_data_demux_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic       req;
    word_t      add;
    logic       we;
    word_t      data;
    logic [3:0] be;
  } core_data_req_t;

  typedef struct packed {
    logic  gnt;
    logic  r_valid;
    word_t r_data;
  } core_data_rsp_t;

  typedef enum logic [1:0] {
    DMX_TCDM   = 2'd0,
    DMX_PERIPH = 2'd1,
    DMX_ERR    = 2'd2
  } core_demux_dest_e;

  localparam word_t CoreDemuxErrRdata = 32'hBADACCE5;

  // Unsigned offset compare; addresses below base never match because of the explicit >= test.
  function automatic logic in_window(word_t addr, word_t base, word_t size);
    word_t off;
    off = addr - base;
    return (addr >= base) && (off < size);
  endfunction

endpackage

// File: rtl/cluster_core_data_demux_decode.sv
// Combinational address-to-destination decoder for the cluster window (TCDM / hole / everything else).
// Zero latency, no state, no flow control.
module cluster_core_data_demux_decode
  import cluster_core_data_demux_pkg::*;
#(
  parameter word_t ClusterBaseAddr   = 32'h1000_0000,
  parameter word_t TcdmSize          = 32'(128 * 1024),
  parameter word_t ClusterPeriphOffs = 32'h0020_0000
) (
  input  logic [31:0]      addr_i,
  output core_demux_dest_e dest_o
);

  always_comb begin
    dest_o = DMX_PERIPH;
    if (in_window(addr_i, ClusterBaseAddr, TcdmSize)) begin
      dest_o = DMX_TCDM;
    end else if (in_window(addr_i, ClusterBaseAddr, ClusterPeriphOffs)) begin
      dest_o = DMX_ERR;
    end
  end

endmodule

// File: rtl/cluster_core_data_demux.sv
// Routes core data requests to TCDM, peripherals or an error responder; responses return in order, 0-cycle passthrough.
// Backpressure: core gnt held low while MaxOutstanding are in flight or while the target switches with requests pending.
module cluster_core_data_demux
  import cluster_core_data_demux_pkg::*;
#(
  parameter word_t       ClusterBaseAddr   = 32'h1000_0000,
  parameter word_t       TcdmSize          = 32'(128 * 1024),
  parameter word_t       ClusterPeriphOffs = 32'h0020_0000,
  parameter int unsigned MaxOutstanding    = 4,
  parameter word_t       ErrRdata          = CoreDemuxErrRdata
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  core_data_req_t core_req_i,
  output core_data_rsp_t core_rsp_o,
  output core_data_req_t tcdm_req_o,
  input  core_data_rsp_t tcdm_rsp_i,
  output core_data_req_t periph_req_o,
  input  core_data_rsp_t periph_rsp_i,
  output logic           err_o,
  output logic           spurious_rsp_o
);

  localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  core_demux_dest_e dest_q, dest_d;
  logic             err_pend_q, err_pend_d;

  core_demux_dest_e dest;
  logic             busy;
  logic             rsp_vld;
  word_t            rsp_dat;
  logic             drains;
  logic             stall;
  logic             fwd;
  logic             tgt_gnt;
  logic             accept;

  cluster_core_data_demux_decode #(
    .ClusterBaseAddr  (ClusterBaseAddr),
    .TcdmSize         (TcdmSize),
    .ClusterPeriphOffs(ClusterPeriphOffs)
  ) i_decode (
    .addr_i(core_req_i.add),
    .dest_o(dest)
  );

  assign busy = (cnt_q != '0);

  always_comb begin
    rsp_vld = 1'b0;
    rsp_dat = '0;
    if (busy) begin
      unique case (dest_q)
        DMX_TCDM: begin
          rsp_vld = tcdm_rsp_i.r_valid;
          rsp_dat = tcdm_rsp_i.r_data;
        end
        DMX_PERIPH: begin
          rsp_vld = periph_rsp_i.r_valid;
          rsp_dat = periph_rsp_i.r_data;
        end
        default: begin
          rsp_vld = err_pend_q;
          rsp_dat = ErrRdata;
        end
      endcase
    end
  end

  // A response retiring the last in-flight item frees the slot/target in the same cycle.
  assign drains = rsp_vld && (cnt_q == CntOne);
  assign stall  = ((cnt_q == CntMax) && !rsp_vld) ||
                  (busy && (dest != dest_q) && !drains);
  assign fwd    = core_req_i.req && !stall && !rst_i;

  always_comb begin
    tcdm_req_o       = core_req_i;
    tcdm_req_o.req   = fwd && (dest == DMX_TCDM);
    periph_req_o     = core_req_i;
    periph_req_o.req = fwd && (dest == DMX_PERIPH);

    unique case (dest)
      DMX_TCDM:   tgt_gnt = tcdm_rsp_i.gnt;
      DMX_PERIPH: tgt_gnt = periph_rsp_i.gnt;
      default:    tgt_gnt = 1'b1;
    endcase

    core_rsp_o.gnt     = fwd && tgt_gnt;
    core_rsp_o.r_valid = rsp_vld;
    core_rsp_o.r_data  = rsp_dat;
  end

  assign accept = core_rsp_o.gnt;
  assign err_o  = rsp_vld && (dest_q == DMX_ERR);

  assign spurious_rsp_o = !rst_i &&
      ((tcdm_rsp_i.r_valid   && !(busy && dest_q == DMX_TCDM)) ||
       (periph_rsp_i.r_valid && !(busy && dest_q == DMX_PERIPH)));

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, rsp_vld})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
    dest_d     = accept ? dest : dest_q;
    err_pend_d = accept && (dest == DMX_ERR);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      dest_q     <= DMX_PERIPH;
      err_pend_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dest_q     <= dest_d;
      err_pend_q <= err_pend_d;
    end
  end

`ifndef SYNTHESIS
  a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= CntMax);
  a_one_req: assert property (@(posedge clk_i) disable iff (rst_i)
                              !(tcdm_req_o.req && periph_req_o.req));
  a_rvld_busy: assert property (@(posedge clk_i) disable iff (rst_i)
                                core_rsp_o.r_valid |-> busy);
`endif

endmodule

// File: tb/tb_cluster_core_data_demux.sv
// Scenario bench for cluster_core_data_demux: directed cases plus a randomized run against an in-order queue model.
module tb_cluster_core_data_demux;
  import cluster_core_data_demux_pkg::*;

  localparam int MAX_OUT = 4;
  localparam word_t ERR_DATA = 32'hBADACCE5;

  logic           clk_i;
  logic           rst_i;
  core_data_req_t core_req;
  core_data_rsp_t core_rsp;
  core_data_req_t tcdm_req;
  core_data_rsp_t tcdm_rsp;
  core_data_req_t periph_req;
  core_data_rsp_t periph_rsp;
  logic           err;
  logic           spur;

  int checks;
  int failures;

  typedef struct packed {
    logic [1:0] dst;
    word_t      dat;
  } exp_t;

  cluster_core_data_demux dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .core_req_i    (core_req),
    .core_rsp_o    (core_rsp),
    .tcdm_req_o    (tcdm_req),
    .tcdm_rsp_i    (tcdm_rsp),
    .periph_req_o  (periph_req),
    .periph_rsp_i  (periph_rsp),
    .err_o         (err),
    .spurious_rsp_o(spur)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle();
    core_req   = '0;
    tcdm_rsp   = '0;
    periph_rsp = '0;
  endtask

  function automatic core_data_req_t mkreq(word_t a, logic we, word_t d);
    core_data_req_t r;
    r.req  = 1'b1;
    r.add  = a;
    r.we   = we;
    r.data = d;
    r.be   = 4'hF;
    return r;
  endfunction

  task automatic test_reset();
    rst_i      = 1'b1;
    core_req   = mkreq(32'h1000_0100, 1'b1, 32'h55);
    tcdm_rsp   = '{gnt: 1'b1, r_valid: 1'b1, r_data: 32'h1};
    periph_rsp = '{gnt: 1'b1, r_valid: 1'b1, r_data: 32'h2};
    #1;
    checks++;
    if (core_rsp !== '0) begin
      failures++; $display("FAIL reset_core_rsp got=%h exp=0", core_rsp);
    end
    checks++;
    if ({tcdm_req.req, periph_req.req, err, spur} !== 4'b0000) begin
      failures++; $display("FAIL reset_outs got=%b exp=0000", {tcdm_req.req, periph_req.req, err, spur});
    end
    checks++;
    if (tcdm_req.add !== 32'h1000_0100 || periph_req.data !== 32'h55) begin
      failures++; $display("FAIL reset_passthru got=%h/%h exp=10000100/55", tcdm_req.add, periph_req.data);
    end
    checks++;
    if (dut.cnt_q !== 0 || dut.dest_q !== DMX_PERIPH || dut.err_pend_q !== 1'b0) begin
      failures++; $display("FAIL reset_state got=%0d/%0d/%b exp=0/1/0", dut.cnt_q, dut.dest_q, dut.err_pend_q);
    end
    tick();
    idle();
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_tcdm_read();
    core_req = mkreq(32'h1000_0100, 1'b0, 32'h0);
    tcdm_rsp = '{gnt: 1'b1, r_valid: 1'b0, r_data: 32'h0};
    #1;
    checks++;
    if ({core_rsp.gnt, tcdm_req.req, periph_req.req, core_rsp.r_valid} !== 4'b1100) begin
      failures++; $display("FAIL tcdm_req got=%b exp=1100", {core_rsp.gnt, tcdm_req.req, periph_req.req, core_rsp.r_valid});
    end
    tick();
    core_req = '0;
    tcdm_rsp = '{gnt: 1'b0, r_valid: 1'b1, r_data: 32'h1234_5678};
    #1;
    checks++;
    if (core_rsp.r_valid !== 1'b1 || core_rsp.r_data !== 32'h1234_5678) begin
      failures++; $display("FAIL tcdm_rsp got=%b/%h exp=1/12345678", core_rsp.r_valid, core_rsp.r_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (dut.cnt_q !== 0 || core_rsp.r_valid !== 1'b0) begin
      failures++; $display("FAIL tcdm_drain got=%0d/%b exp=0/0", dut.cnt_q, core_rsp.r_valid);
    end
    tick();
  endtask

  task automatic test_periph_stall();
    for (int i = 0; i < 4; i++) begin
      core_req   = mkreq(32'h1A10_0000, 1'b1, word_t'(i));
      periph_rsp = '{gnt: 1'b1, r_valid: 1'b0, r_data: 32'h0};
      #1;
      checks++;
      if ({core_rsp.gnt, periph_req.req, tcdm_req.req} !== 3'b110) begin
        failures++; $display("FAIL periph_wr%0d got=%b exp=110", i, {core_rsp.gnt, periph_req.req, tcdm_req.req});
      end
      tick();
    end
    core_req = mkreq(32'h1A10_0000, 1'b1, 32'h99);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({core_rsp.gnt, periph_req.req} !== 2'b00) begin
        failures++; $display("FAIL periph_full%0d got=%b exp=00", i, {core_rsp.gnt, periph_req.req});
      end
      tick();
    end
    periph_rsp.r_valid = 1'b1;
    #1;
    checks++;
    if ({core_rsp.gnt, periph_req.req, core_rsp.r_valid} !== 3'b111) begin
      failures++; $display("FAIL periph_refill got=%b exp=111", {core_rsp.gnt, periph_req.req, core_rsp.r_valid});
    end
    tick();
    idle();
    #1;
    checks++;
    if (dut.cnt_q !== 4) begin
      failures++; $display("FAIL periph_cnt4 got=%0d exp=4", dut.cnt_q);
    end
    for (int i = 0; i < 4; i++) begin
      periph_rsp = '{gnt: 1'b0, r_valid: 1'b1, r_data: 32'hC0DE_0000 + word_t'(i)};
      #1;
      checks++;
      if (core_rsp.r_valid !== 1'b1 || core_rsp.r_data !== 32'hC0DE_0000 + word_t'(i)) begin
        failures++; $display("FAIL periph_drain%0d got=%b/%h", i, core_rsp.r_valid, core_rsp.r_data);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (dut.cnt_q !== 0) begin
      failures++; $display("FAIL periph_cnt0 got=%0d exp=0", dut.cnt_q);
    end
    tick();
  endtask

  task automatic test_order();
    core_req   = mkreq(32'h1A10_0004, 1'b0, 32'h0);
    periph_rsp = '{gnt: 1'b1, r_valid: 1'b0, r_data: 32'h0};
    #1;
    checks++;
    if ({core_rsp.gnt, periph_req.req} !== 2'b11) begin
      failures++; $display("FAIL order_periph got=%b exp=11", {core_rsp.gnt, periph_req.req});
    end
    tick();
    core_req   = mkreq(32'h1000_0000, 1'b0, 32'h0);
    tcdm_rsp   = '{gnt: 1'b1, r_valid: 1'b0, r_data: 32'h0};
    periph_rsp = '0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({core_rsp.gnt, tcdm_req.req, periph_req.req} !== 3'b000) begin
        failures++; $display("FAIL order_hold%0d got=%b exp=000", i, {core_rsp.gnt, tcdm_req.req, periph_req.req});
      end
      tick();
    end
    periph_rsp = '{gnt: 1'b0, r_valid: 1'b1, r_data: 32'hAAAA_0001};
    #1;
    checks++;
    if ({core_rsp.gnt, tcdm_req.req, core_rsp.r_valid} !== 3'b111 || core_rsp.r_data !== 32'hAAAA_0001) begin
      failures++; $display("FAIL order_switch got=%b/%h exp=111/aaaa0001", {core_rsp.gnt, tcdm_req.req, core_rsp.r_valid}, core_rsp.r_data);
    end
    tick();
    idle();
    tcdm_rsp = '{gnt: 1'b0, r_valid: 1'b1, r_data: 32'hBBBB_0002};
    #1;
    checks++;
    if (core_rsp.r_valid !== 1'b1 || core_rsp.r_data !== 32'hBBBB_0002 || spur !== 1'b0) begin
      failures++; $display("FAIL order_second got=%b/%h/%b exp=1/bbbb0002/0", core_rsp.r_valid, core_rsp.r_data, spur);
    end
    tick();
    idle();
    #1;
    checks++;
    if (dut.cnt_q !== 0) begin
      failures++; $display("FAIL order_cnt0 got=%0d exp=0", dut.cnt_q);
    end
    tick();
  endtask

  task automatic test_err();
    core_req = mkreq(32'h1010_0000, 1'b0, 32'h0);
    #1;
    checks++;
    if ({core_rsp.gnt, tcdm_req.req, periph_req.req, core_rsp.r_valid, err} !== 5'b10000) begin
      failures++; $display("FAIL err_gnt got=%b exp=10000", {core_rsp.gnt, tcdm_req.req, periph_req.req, core_rsp.r_valid, err});
    end
    tick();
    idle();
    #1;
    checks++;
    if ({core_rsp.r_valid, err} !== 2'b11 || core_rsp.r_data !== ERR_DATA) begin
      failures++; $display("FAIL err_rsp got=%b/%h exp=11/badacce5", {core_rsp.r_valid, err}, core_rsp.r_data);
    end
    tick();
    #1;
    checks++;
    if ({core_rsp.r_valid, err} !== 2'b00 || dut.cnt_q !== 0) begin
      failures++; $display("FAIL err_done got=%b/%0d exp=00/0", {core_rsp.r_valid, err}, dut.cnt_q);
    end
    for (int i = 0; i < 3; i++) begin
      core_req = mkreq(32'h1010_0000 + word_t'(4 * i), 1'b0, 32'h0);
      #1;
      checks++;
      if ({core_rsp.gnt, core_rsp.r_valid, err} !== {1'b1, i > 0, i > 0}) begin
        failures++; $display("FAIL err_b2b%0d got=%b", i, {core_rsp.gnt, core_rsp.r_valid, err});
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if ({core_rsp.r_valid, err} !== 2'b11 || core_rsp.r_data !== ERR_DATA) begin
      failures++; $display("FAIL err_b2b_last got=%b/%h", {core_rsp.r_valid, err}, core_rsp.r_data);
    end
    tick();
  endtask

  task automatic test_spurious();
    idle();
    tcdm_rsp = '{gnt: 1'b0, r_valid: 1'b1, r_data: 32'hDEAD_BEEF};
    #1;
    checks++;
    if ({core_rsp.r_valid, spur} !== 2'b01) begin
      failures++; $display("FAIL spur_tcdm got=%b exp=01", {core_rsp.r_valid, spur});
    end
    tick();
    idle();
    #1;
    checks++;
    if (spur !== 1'b0) begin
      failures++; $display("FAIL spur_clear got=%b exp=0", spur);
    end
    periph_rsp = '{gnt: 1'b0, r_valid: 1'b1, r_data: 32'h1};
    #1;
    checks++;
    if ({core_rsp.r_valid, spur} !== 2'b01) begin
      failures++; $display("FAIL spur_periph got=%b exp=01", {core_rsp.r_valid, spur});
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_decode_bounds();
    word_t      addrs [7] = '{32'h1000_0000, 32'h1001_FFFC, 32'h1002_0000, 32'h101F_FFFC,
                              32'h1020_0000, 32'h0FFF_FFFC, 32'hFFFF_FFFC};
    logic [2:0] exps  [7] = '{3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001};
    for (int i = 0; i < 7; i++) begin
      idle();
      core_req = mkreq(addrs[i], 1'b0, 32'h0);
      #1;
      checks++;
      if ({core_rsp.gnt, tcdm_req.req, periph_req.req} !== exps[i]) begin
        failures++; $display("FAIL decode_%h got=%b exp=%b", addrs[i], {core_rsp.gnt, tcdm_req.req, periph_req.req}, exps[i]);
      end
      tick();
      idle();
      if (exps[i] == 3'b100) begin
        #1;
        checks++;
        if (err !== 1'b1) begin
          failures++; $display("FAIL decode_err_%h got=%b exp=1", addrs[i], err);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      core_req   = mkreq(32'h1A10_0100 + word_t'(4 * i), 1'b0, 32'h0);
      periph_rsp = '{gnt: 1'b1, r_valid: 1'b0, r_data: 32'h0};
      tick();
    end
    rst_i    = 1'b1;
    core_req = mkreq(32'h1000_0040, 1'b0, 32'h0);
    tcdm_rsp = '{gnt: 1'b1, r_valid: 1'b0, r_data: 32'h0};
    #1;
    checks++;
    if (core_rsp !== '0 || {tcdm_req.req, periph_req.req, err, spur} !== 4'b0000 || dut.cnt_q !== 0) begin
      failures++; $display("FAIL rstmid_outs got=%h/%b/%0d", core_rsp, {tcdm_req.req, periph_req.req, err, spur}, dut.cnt_q);
    end
    tick();
    rst_i = 1'b0;
    idle();
    for (int i = 0; i < 2; i++) begin
      periph_rsp = '{gnt: 1'b0, r_valid: 1'b1, r_data: 32'h7777_0000 + word_t'(i)};
      #1;
      checks++;
      if ({core_rsp.r_valid, spur} !== 2'b01) begin
        failures++; $display("FAIL rstmid_late%0d got=%b exp=01", i, {core_rsp.r_valid, spur});
      end
      tick();
    end
    idle();
    core_req = mkreq(32'h1000_0200, 1'b0, 32'h0);
    tcdm_rsp = '{gnt: 1'b1, r_valid: 1'b0, r_data: 32'h0};
    #1;
    checks++;
    if ({core_rsp.gnt, tcdm_req.req} !== 2'b11) begin
      failures++; $display("FAIL rstmid_tcdm_gnt got=%b exp=11", {core_rsp.gnt, tcdm_req.req});
    end
    tick();
    idle();
    tcdm_rsp = '{gnt: 1'b0, r_valid: 1'b1, r_data: 32'h0BAD_F00D};
    #1;
    checks++;
    if (core_rsp.r_valid !== 1'b1 || core_rsp.r_data !== 32'h0BAD_F00D || spur !== 1'b0) begin
      failures++; $display("FAIL rstmid_tcdm_rsp got=%b/%h/%b", core_rsp.r_valid, core_rsp.r_data, spur);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_random();
    exp_t  exp_q[$];
    word_t tcdm_q[$];
    word_t periph_q[$];
    bit    err_due = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit    allow_req, t_rv, p_rv, t_sp, p_sp, rsp_now, blocked, e_fwd, e_gnt, t_g, p_g;
      int    dst, after;
      word_t a;
      allow_req = (cyc < 380);
      t_sp = 1'b0;
      p_sp = 1'b0;
      t_rv = (tcdm_q.size() > 0) && (!allow_req || $urandom_range(1, 0) == 1);
      p_rv = (periph_q.size() > 0) && (!allow_req || $urandom_range(1, 0) == 1);
      if (allow_req && tcdm_q.size() == 0 && $urandom_range(15, 0) == 0) t_sp = 1'b1;
      if (allow_req && periph_q.size() == 0 && $urandom_range(15, 0) == 0) p_sp = 1'b1;
      t_g = ($urandom_range(3, 0) != 0);
      p_g = ($urandom_range(3, 0) != 0);
      dst = int'($urandom_range(2, 0));
      unique case (dst)
        0: a = 32'h1000_0000 + ($urandom_range(32'h1_FFFF, 0) & ~32'd3);
        1: a = ($urandom_range(1, 0) == 1) ? 32'h1A10_0000 + $urandom_range(255, 0)
                                           : 32'h0000_1000 + $urandom_range(255, 0);
        default: a = 32'h1002_0000 + $urandom_range(32'h1D_FFFF, 0);
      endcase
      core_req      = mkreq(a, 1'($urandom_range(1, 0)), $urandom);
      core_req.be   = 4'($urandom_range(15, 0));
      core_req.req  = allow_req && ($urandom_range(9, 0) < 7);
      tcdm_rsp      = '{gnt: t_g, r_valid: t_rv | t_sp, r_data: t_rv ? tcdm_q[0] : $urandom};
      periph_rsp    = '{gnt: p_g, r_valid: p_rv | p_sp, r_data: p_rv ? periph_q[0] : $urandom};

      rsp_now = t_rv || p_rv || err_due;
      after   = exp_q.size() - int'(rsp_now);
      blocked = (after >= MAX_OUT) || (after != 0 && dst != int'(exp_q[$].dst));
      e_fwd   = core_req.req && !blocked;
      e_gnt   = e_fwd && (dst == 2 || (dst == 0 && t_g) || (dst == 1 && p_g));
      #1;
      checks++;
      if ({core_rsp.gnt, tcdm_req.req, periph_req.req} !== {e_gnt, e_fwd && dst == 0, e_fwd && dst == 1}) begin
        failures++; $display("FAIL rand_req cyc=%0d got=%b exp=%b", cyc,
          {core_rsp.gnt, tcdm_req.req, periph_req.req}, {e_gnt, e_fwd && dst == 0, e_fwd && dst == 1});
      end
      checks++;
      if (core_rsp.r_valid !== rsp_now || (rsp_now && core_rsp.r_data !== exp_q[0].dat)) begin
        failures++; $display("FAIL rand_rsp cyc=%0d got=%b/%h exp=%b/%h", cyc, core_rsp.r_valid,
          core_rsp.r_data, rsp_now, rsp_now ? exp_q[0].dat : 32'h0);
      end
      checks++;
      if ({err, spur} !== {rsp_now && exp_q[0].dst == 2'd2, t_sp || p_sp}) begin
        failures++; $display("FAIL rand_flags cyc=%0d got=%b exp=%b", cyc, {err, spur},
          {rsp_now && exp_q[0].dst == 2'd2, t_sp || p_sp});
      end
      checks++;
      if ({tcdm_req.add, tcdm_req.we, tcdm_req.data, periph_req.be} !==
          {core_req.add, core_req.we, core_req.data, core_req.be}) begin
        failures++; $display("FAIL rand_passthru cyc=%0d got=%h exp=%h", cyc, tcdm_req.add, core_req.add);
      end
      if (rsp_now) void'(exp_q.pop_front());
      if (t_rv) void'(tcdm_q.pop_front());
      if (p_rv) void'(periph_q.pop_front());
      if (e_gnt) begin
        exp_t e;
        e.dst = 2'(dst);
        e.dat = (dst == 2) ? ERR_DATA : $urandom;
        exp_q.push_back(e);
        if (dst == 0) tcdm_q.push_back(e.dat);
        if (dst == 1) periph_q.push_back(e.dat);
      end
      err_due = e_gnt && dst == 2;
      tick();
    end
    idle();
    #1;
    checks++;
    if (exp_q.size() != 0 || dut.cnt_q !== 0) begin
      failures++; $display("FAIL rand_drain left=%0d cnt=%0d exp=0/0", exp_q.size(), dut.cnt_q);
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    test_reset();
    test_tcdm_read();
    test_periph_stall();
    test_order();
    test_err();
    test_spurious();
    test_decode_bounds();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
